// File: rtl/disp_scan_pkg.sv
// Shared defaults and elaboration-time helpers for the display scan multiplexer.
package disp_scan_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DIV   = 50000;
    localparam int DEF_BLANK = 2;

    // Bits needed to hold 0..value-1; never less than 1 so ports stay legal.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/disp_next_ch.sv
// Combinational search for the next enabled channel after cur_i, ascending with wrap.
module disp_next_ch
    import disp_scan_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int IW  = clog2(DEF_NCH)
) (
    input  logic [NCH-1:0] mask_i,
    input  logic [IW-1:0]  cur_i,
    output logic [IW-1:0]  nxt_o,
    output logic           valid_o
);

    logic [IW-1:0]  cand_idx [NCH];
    logic [NCH-1:0] cand_en;

    // Candidate gi is the channel gi+1 steps ahead; the last candidate is cur_i itself.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_cand
            assign cand_idx[gi] = IW'((int'(cur_i) + gi + 1) % NCH);
            assign cand_en[gi]  = mask_i[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        nxt_o = cur_i;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (cand_en[k]) begin
                nxt_o = cand_idx[k];
            end
        end
    end

    assign valid_o = |mask_i;

endmodule

// File: rtl/disp_scan_mux.sv
// Multiplexed display scanner: rotating or manual channel select with post-switch blanking.
module disp_scan_mux
    import disp_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int DIV   = DEF_DIV,
    parameter int BLANK = DEF_BLANK
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [NCH-1:0]         ch_mask,
    input  logic                   auto,
    input  logic [clog2(NCH)-1:0]  man_sel,
    input  logic                   hold,
    output logic [WIDTH-1:0]       seg_out,
    output logic [NCH-1:0]         dig_en,
    output logic [clog2(NCH)-1:0]  ch_idx,
    output logic                   tick
);

    localparam int IW = clog2(NCH);
    localparam int PW = clog2(DIV);
    localparam int BW = clog2(BLANK + 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [IW-1:0]    ch_q, ch_d;
    logic [WIDTH-1:0] seg_q, seg_d;
    logic [NCH-1:0]   dig_q, dig_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic             show;
    logic             man_ok;
    logic [NCH-1:0]   man_hit;
    logic [NCH-1:0]   onehot;
    logic [WIDTH-1:0] chan [NCH];
    logic [IW-1:0]    nxt_idx;
    logic             nxt_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign chan[gi]    = din[gi*WIDTH +: WIDTH];
            assign man_hit[gi] = (man_sel == IW'(gi));
            assign onehot[gi]  = (ch_d == IW'(gi));
        end
    endgenerate

    // Out-of-range man_sel matches no channel and is therefore ignored.
    assign man_ok = |man_hit;

    disp_next_ch #(
        .NCH (NCH),
        .IW  (IW)
    ) u_next (
        .mask_i  (ch_mask),
        .cur_i   (ch_q),
        .nxt_o   (nxt_idx),
        .valid_o (nxt_valid)
    );

    always_comb begin
        wrap    = ~hold && (pre_q == PW'(DIV - 1));
        pre_d   = pre_q;
        tick_d  = 1'b0;
        ch_d    = ch_q;
        blank_d = blank_q;

        if (wrap) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end else if (~hold) begin
            pre_d = pre_q + PW'(1);
        end

        // A manual change overrides any wrap in the same cycle and restarts the dwell.
        if (auto) begin
            if (wrap && nxt_valid) begin
                ch_d = nxt_idx;
            end
        end else if (man_ok && (man_sel != ch_q)) begin
            ch_d  = man_sel;
            pre_d = '0;
        end

        if (ch_d != ch_q) begin
            blank_d = BW'(BLANK);
        end else if (blank_q != '0) begin
            blank_d = blank_q - BW'(1);
        end
    end

    // Decide visibility from the post-edge state so blanking lasts exactly BLANK cycles.
    assign show  = (blank_d == '0) && ch_mask[ch_d];
    assign seg_d = show ? chan[ch_d] : '0;
    assign dig_d = show ? onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            blank_q <= BW'(BLANK);
            ch_q    <= '0;
            seg_q   <= '0;
            dig_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            blank_q <= blank_d;
            ch_q    <= ch_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            tick_q  <= tick_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_en  = dig_q;
    assign ch_idx  = ch_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux with a cycle-level behavioural model and literal checkpoints.
module tb_disp_scan_mux;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] din;
    logic [N-1:0]   ch_mask;
    logic           auto_s;
    logic [1:0]     man_sel;
    logic           hold;
    logic [W-1:0]   seg_out;
    logic [N-1:0]   dig_en;
    logic [1:0]     ch_idx;
    logic           tick;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    disp_scan_mux #(
        .WIDTH (W),
        .NCH   (N),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .ch_mask (ch_mask),
        .auto    (auto_s),
        .man_sel (man_sel),
        .hold    (hold),
        .seg_out (seg_out),
        .dig_en  (dig_en),
        .ch_idx  (ch_idx),
        .tick    (tick)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: phase within the dwell, displayed channel, cycles since last channel change.
    int           m_pre = 0;
    int           m_ch = 0;
    int           m_since = 0;
    int           m_new;
    bit           m_wrap;
    logic [W-1:0] m_seg = '0;
    logic [N-1:0] m_dig = '0;
    logic         m_tick = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pre = 0; m_ch = 0; m_since = 0;
            m_seg = '0; m_dig = '0; m_tick = 1'b0;
        end else begin
            m_wrap = !hold && (m_pre == DIV - 1);
            m_tick = m_wrap;
            if (m_wrap) m_pre = 0;
            else if (!hold) m_pre = m_pre + 1;
            m_new = m_ch;
            if (auto_s) begin
                if (m_wrap)
                    for (int k = N; k >= 1; k--)
                        if (ch_mask[(m_ch + k) % N]) m_new = (m_ch + k) % N;
            end else if (int'(man_sel) != m_ch) begin
                m_new = int'(man_sel);
                m_pre = 0;
            end
            if (m_new != m_ch) m_since = 0;
            else if (m_since < BLANK) m_since = m_since + 1;
            m_ch = m_new;
            if (m_since >= BLANK && ch_mask[m_ch]) begin
                m_seg = din[m_ch*W +: W];
                m_dig = 4'(1 << m_ch);
            end else begin
                m_seg = '0;
                m_dig = '0;
            end
            #1;
            if (mon_en && rst_n) begin
                check("mdl_seg", 64'(seg_out), 64'(m_seg));
                check("mdl_dig", 64'(dig_en), 64'(m_dig));
                check("mdl_ch", 64'(ch_idx), 64'(m_ch));
                check("mdl_tick", 64'(tick), 64'(m_tick));
            end
        end
    end

    logic [63:0] seq;
    logic [7:0]  last;
    int          ticks;

    initial begin
        din     = {8'h44, 8'h33, 8'h22, 8'h11};
        ch_mask = 4'b1111;
        auto_s  = 1'b1;
        man_sel = 2'd0;
        hold    = 1'b0;
        mon_en  = 1'b1;

        #1;
        check("rst_seg", 64'(seg_out), 64'h0);
        check("rst_dig", 64'(dig_en), 64'h0);
        check("rst_ch", 64'(ch_idx), 64'h0);
        check("rst_tick", 64'(tick), 64'h0);

        step(2);
        rst_n = 1'b1;
        step(1);
        check("blank1_seg", 64'(seg_out), 64'h0);
        step(1);
        check("show0_seg", 64'(seg_out), 64'h11);
        check("show0_dig", 64'(dig_en), 64'h1);

        // Auto rotation over all four channels.
        seq = 64'h11; last = 8'h11; ticks = 0;
        for (int i = 0; i < 34; i++) begin
            step(1);
            if (tick) ticks++;
            if (seg_out != 8'h0 && seg_out != last) begin
                seq = {seq[55:0], seg_out};
                last = seg_out;
            end
        end
        check("auto_seq", seq, 64'h1122334411);
        check("auto_ticks", 64'(ticks), 64'd4);

        // Reset mid-dwell on channel 1.
        step(7);
        check("pre_rst_seg", 64'(seg_out), 64'h22);
        rst_n = 1'b0;
        #1;
        check("async_seg", 64'(seg_out), 64'h0);
        check("async_dig", 64'(dig_en), 64'h0);
        check("async_ch", 64'(ch_idx), 64'h0);

        // Sparse mask 1010.
        step(2);
        ch_mask = 4'b1010;
        rst_n = 1'b1;
        seq = 64'h0; last = 8'h0;
        for (int i = 0; i < 34; i++) begin
            step(1);
            if (8'(ch_idx) != last) begin
                seq = {seq[59:0], 4'(ch_idx)};
                last = 8'(ch_idx);
            end
        end
        check("mask_chseq", seq, 64'h1313);
        check("mask_dig3", 64'(dig_en), 64'h8);
        ch_mask = 4'b0010;
        step(1);
        check("unmask_seg", 64'(seg_out), 64'h0);
        check("unmask_dig", 64'(dig_en), 64'h0);
        step(7);
        check("skip_ch", 64'(ch_idx), 64'h1);
        check("skip_seg", 64'(seg_out), 64'h22);
        step(16);
        check("single_ch", 64'(ch_idx), 64'h1);
        check("single_dig", 64'(dig_en), 64'h2);

        // Manual selection.
        ch_mask = 4'b1111;
        auto_s = 1'b0;
        man_sel = 2'd2;
        step(1);
        check("man_ch2", 64'(ch_idx), 64'h2);
        check("man_blank", 64'(seg_out), 64'h0);
        step(2);
        check("man_seg33", 64'(seg_out), 64'h33);
        ch_mask = 4'b0111;
        man_sel = 2'd3;
        step(1);
        check("man_ch3", 64'(ch_idx), 64'h3);
        step(3);
        check("man_off_seg", 64'(seg_out), 64'h0);
        check("man_off_dig", 64'(dig_en), 64'h0);

        // Hold freezes the prescaler while data still tracks din.
        ch_mask = 4'b1111;
        man_sel = 2'd1;
        step(3);
        check("hold_pre_seg", 64'(seg_out), 64'h22);
        auto_s = 1'b1;
        hold = 1'b1;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick) ticks++;
        end
        check("hold_ticks", 64'(ticks), 64'd0);
        check("hold_ch", 64'(ch_idx), 64'h1);
        din[15:8] = 8'h5A;
        step(1);
        check("hold_track", 64'(seg_out), 64'h5A);

        // Empty mask: dark outputs, channel held, prescaler still running.
        hold = 1'b0;
        ch_mask = 4'b0000;
        step(1);
        check("empty_seg", 64'(seg_out), 64'h0);
        check("empty_dig", 64'(dig_en), 64'h0);
        ticks = 0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (tick) ticks++;
        end
        check("empty_ticks", 64'(ticks), 64'd3);
        check("empty_ch", 64'(ch_idx), 64'h1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
